// File: rtl/btn_reset_pkg.sv
// btn_reset_pkg: reset FSM state type and timing helpers for btn_reset_conditioner
package btn_reset_pkg;
  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RUN} t_rst_state;
  function automatic int f_debounce_cycles(input int clk_hz, input int ms, input int sim);
    return sim != 0 ? 16 : clk_hz / 1000 * ms;
  endfunction
  function automatic int f_hold_cycles(input int hold, input int sim);
    return sim != 0 ? 32 : hold;
  endfunction
  function automatic int f_cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: one button channel - 2-FF synchroniser, debounce counter, level and edge strobes
module btn_debouncer
  import btn_reset_pkg::*;
#(
  parameter int g_cycles = 16,
  parameter int g_cnt_w  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press_p,
  output logic release_p
);
  localparam logic [g_cnt_w-1:0] c_last = g_cnt_w'(g_cycles - 1);
  logic [1:0] sync;
  logic [g_cnt_w-1:0] cnt;
  logic prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= '0;
      cnt       <= '0;
      level     <= 1'b0;
      prev      <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
    end else begin
      sync      <= {sync[0], btn};
      cnt       <= (sync[1] == level || cnt == c_last) ? '0 : cnt + 1'b1;
      if (sync[1] != level && cnt == c_last) level <= sync[1];
      prev      <= level;
      press_p   <= level & ~prev;
      release_p <= ~level & prev;
    end
  end
endmodule

// File: rtl/btn_reset_conditioner.sv
// btn_reset_conditioner: debounced buttons with strobes and a held, glitch-free system reset
module btn_reset_conditioner
  import btn_reset_pkg::*;
#(
  parameter int g_num_buttons       = 2,
  parameter int g_reset_btn         = 0,
  parameter int g_clk_freq_hz       = 12000000,
  parameter int g_debounce_ms       = 10,
  parameter int g_reset_hold_cycles = 4096,
  parameter int g_simulation        = 0
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_n_i,
  input  logic [g_num_buttons-1:0] btn_i,
  output logic [g_num_buttons-1:0] btn_o,
  output logic [g_num_buttons-1:0] btn_press_p_o,
  output logic [g_num_buttons-1:0] btn_release_p_o,
  output logic                     rst_sys_n_o,
  output logic                     rst_done_p_o
);
  localparam int c_db   = f_debounce_cycles(g_clk_freq_hz, g_debounce_ms, g_simulation);
  localparam int c_hold = f_hold_cycles(g_reset_hold_cycles, g_simulation);
  localparam int c_w    = f_cnt_width(c_db, c_hold);
  localparam logic [c_w-1:0] c_hold_last = c_w'(c_hold - 1);
  t_rst_state state, state_nxt;
  logic [c_w-1:0] hcnt;
  logic r;
  for (genvar g = 0; g < g_num_buttons; g++) begin : gen_db
    btn_debouncer #(.g_cycles(c_db), .g_cnt_w(c_w)) u_db (
      .clk      (clk_sys_i),
      .rst_n    (rst_n_i),
      .btn      (btn_i[g]),
      .level    (btn_o[g]),
      .press_p  (btn_press_p_o[g]),
      .release_p(btn_release_p_o[g])
    );
  end
  assign r = btn_o[g_reset_btn];
  always_comb
    state_nxt = r ? ST_ASSERT :
                (state == ST_HOLD && hcnt == c_hold_last) ? ST_RUN :
                (state == ST_ASSERT) ? ST_HOLD : state;
  // hcnt counts cycles the reset button has been low, so the leaving cycle of ST_ASSERT counts as the first
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_HOLD;
      hcnt         <= '0;
      rst_sys_n_o  <= 1'b0;
      rst_done_p_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      hcnt         <= (state_nxt == ST_HOLD) ? hcnt + 1'b1 : '0;
      rst_sys_n_o  <= state_nxt == ST_RUN;
      rst_done_p_o <= state_nxt == ST_RUN && state != ST_RUN;
    end
  end
endmodule

// File: tb/tb_btn_reset_conditioner.sv
// tb_btn_reset_conditioner: directed stimulus with an event scoreboard on strobes and reset-done
module tb_btn_reset_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [1:0] btn_o, press_p, release_p;
  logic rst_sys_n, rst_done;
  logic [7:0] act;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ev_id = 0;
  typedef struct {int cyc; logic [7:0] vec; int id;} t_exp;
  t_exp q[$];
  t_exp mon_e;

  btn_reset_conditioner #(
    .g_num_buttons(2), .g_reset_btn(0), .g_clk_freq_hz(12000000),
    .g_debounce_ms(10), .g_reset_hold_cycles(4096), .g_simulation(1)
  ) dut (
    .clk_sys_i(clk), .rst_n_i(rst_n), .btn_i(btn), .btn_o(btn_o),
    .btn_press_p_o(press_p), .btn_release_p_o(release_p),
    .rst_sys_n_o(rst_sys_n), .rst_done_p_o(rst_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign act = {press_p, release_p, rst_done, rst_sys_n, btn_o};

  function automatic logic [7:0] ev(input logic [1:0] pr, input logic [1:0] rl,
                                    input logic d, input logic rn, input logic [1:0] b);
    return {pr, rl, d, rn, b};
  endfunction

  // Monitor: every strobe or reset-done must match the next expected event exactly
  always @(negedge clk) begin
    if (|{press_p, release_p, rst_done}) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got=%b", cyc, act);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec != act) begin
          errors++;
          $display("FAIL event%0d got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                   mon_e.id, cyc, act, mon_e.cyc, mon_e.vec);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [7:0] v);
    q.push_back('{c, v, ev_id});
    ev_id++;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  initial begin
    int p, r, r3, c;
    #2 rst_n = 1'b0;
    tick(3);
    chk("reset_state", act, 8'h00);
    // power-up hold
    rst_n = 1'b1;
    c = cyc;
    expect_ev(c + 32, ev(2'b00, 2'b00, 1'b1, 1'b1, 2'b00));
    tick(31);
    chk("powerup_hold_low", {7'b0, rst_sys_n}, 8'h00);
    tick(1);
    chk("powerup_released", {7'b0, rst_sys_n}, 8'h01);
    tick(1);
    chk("done_one_cycle", {7'b0, rst_done}, 8'h00);
    tick(5);
    // button 1 press/release latency
    p = cyc;
    btn[1] = 1'b1;
    expect_ev(p + 19, ev(2'b10, 2'b00, 1'b0, 1'b1, 2'b10));
    tick(17);
    chk("b1_before_db", {6'b0, btn_o}, 8'h00);
    tick(1);
    chk("b1_after_db", {6'b0, btn_o}, 8'h02);
    tick(12);
    r = cyc;
    btn[1] = 1'b0;
    expect_ev(r + 19, ev(2'b00, 2'b10, 1'b0, 1'b1, 2'b00));
    tick(18);
    chk("b1_released", {6'b0, btn_o}, 8'h00);
    tick(6);
    // glitches shorter than the debounce window
    repeat (5) begin
      btn[1] = 1'b1;
      tick(10);
      btn[1] = 1'b0;
      tick(3);
    end
    tick(30);
    chk("glitch_level", {6'b0, btn_o}, 8'h00);
    // reset button held in run
    p = cyc;
    btn[0] = 1'b1;
    expect_ev(p + 19, ev(2'b01, 2'b00, 1'b0, 1'b0, 2'b01));
    tick(18);
    chk("rst_before_fall", {7'b0, rst_sys_n}, 8'h01);
    tick(1);
    chk("rst_fall", {7'b0, rst_sys_n}, 8'h00);
    tick(81);
    r = cyc;
    btn[0] = 1'b0;
    expect_ev(r + 19, ev(2'b00, 2'b01, 1'b0, 1'b0, 2'b00));
    expect_ev(r + 50, ev(2'b00, 2'b00, 1'b1, 1'b1, 2'b00));
    tick(49);
    chk("rst_hold_end_low", {7'b0, rst_sys_n}, 8'h00);
    tick(1);
    chk("rst_rise", {7'b0, rst_sys_n}, 8'h01);
    tick(5);
    // re-press at hold count 20 restarts the hold
    p = cyc;
    btn[0] = 1'b1;
    expect_ev(p + 19, ev(2'b01, 2'b00, 1'b0, 1'b0, 2'b01));
    tick(40);
    r = cyc;
    btn[0] = 1'b0;
    expect_ev(r + 19, ev(2'b00, 2'b01, 1'b0, 1'b0, 2'b00));
    tick(20);
    btn[0] = 1'b1;
    expect_ev(r + 39, ev(2'b01, 2'b00, 1'b0, 1'b0, 2'b01));
    tick(40);
    r3 = cyc;
    btn[0] = 1'b0;
    expect_ev(r3 + 19, ev(2'b00, 2'b01, 1'b0, 1'b0, 2'b00));
    expect_ev(r3 + 50, ev(2'b00, 2'b00, 1'b1, 1'b1, 2'b00));
    tick(49);
    chk("repress_hold_low", {7'b0, rst_sys_n}, 8'h00);
    tick(1);
    chk("repress_rise", {7'b0, rst_sys_n}, 8'h01);
    tick(5);
    // asynchronous reset with outputs active, then mid-debounce and mid-hold
    p = cyc;
    btn[1] = 1'b1;
    expect_ev(p + 19, ev(2'b10, 2'b00, 1'b0, 1'b1, 2'b10));
    tick(25);
    chk("pre_async_active", act, 8'h06);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", act, 8'h00);
    tick(3);
    rst_n = 1'b1;
    tick(10);
    rst_n = 1'b0;
    #1 chk("async_mid_hold", act, 8'h00);
    tick(2);
    rst_n = 1'b1;
    c = cyc;
    expect_ev(c + 19, ev(2'b10, 2'b00, 1'b0, 1'b0, 2'b10));
    expect_ev(c + 32, ev(2'b00, 2'b00, 1'b1, 1'b1, 2'b10));
    tick(40);
    r = cyc;
    btn[1] = 1'b0;
    expect_ev(r + 19, ev(2'b00, 2'b10, 1'b0, 1'b1, 2'b00));
    tick(25);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
